// File: rtl/execute_pkg.sv
// Shared definitions for the execute stage: aluOp encodings, multiply/divide
// FSM states and the iteration count.
package execute_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_NOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLL   = 4'd6;
    localparam logic [3:0] ALU_SRL   = 4'd7;
    localparam logic [3:0] ALU_MFHI  = 4'd8;
    localparam logic [3:0] ALU_MFLO  = 4'd9;
    localparam logic [3:0] ALU_MULT  = 4'd10;
    localparam logic [3:0] ALU_MULTU = 4'd11;
    localparam logic [3:0] ALU_DIV   = 4'd12;
    localparam logic [3:0] ALU_DIVU  = 4'd13;

    localparam int MD_ITERS = 32;
    localparam int CNT_W    = $clog2(MD_ITERS);

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FIX,
        MD_DONE
    } md_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply / restoring divide with HI/LO registers.
// The divide datapath is present only when EXECUTE_DIV_EN is defined.
module muldiv_unit
    import execute_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e        state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      work_q, work_d;
    logic [31:0]      opb_q, opb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic             start_is_div;
    logic             start_sgn;
    logic [32:0]      mul_sum;
    logic [63:0]      prod_mag;
    logic [63:0]      prod_fix;

    assign start_is_div = (op == ALU_DIV) || (op == ALU_DIVU);
    assign start_sgn    = (op == ALU_MULT) || (op == ALU_DIV);

    // Shift-add step: {acc,work} holds the partial product above the
    // not-yet-consumed multiplier bits.
    assign mul_sum  = {1'b0, acc_q} + (work_q[0] ? {1'b0, opb_q} : 33'd0);
    assign prod_mag = {acc_q, work_q};
    assign prod_fix = neg_q ? (64'd0 - prod_mag) : prod_mag;

`ifdef EXECUTE_DIV_EN
    logic        div_q, div_d;
    logic        div0_q, div0_d;
    logic        neg_rem_q, neg_rem_d;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_sub;

    // Restoring step: acc is the partial remainder, work shifts the dividend
    // out at the top and collects quotient bits at the bottom.
    assign rem_sh  = {acc_q, work_q[31]};
    assign rem_ge  = rem_sh >= {1'b0, opb_q};
    assign rem_sub = rem_sh[31:0] - opb_q;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        work_d  = work_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = done_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef EXECUTE_DIV_EN
        div_d     = div_q;
        div0_d    = div0_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            MD_IDLE: begin
                if (start && is_muldiv(op)) begin
`ifndef EXECUTE_DIV_EN
                    if (start_is_div) begin
                        state_d = MD_DONE;
                        done_d  = 1'b1;
                    end else begin
`else
                    begin
`endif
                        acc_d   = '0;
                        work_d  = magnitude(rs, start_sgn);
                        opb_d   = magnitude(rt, start_sgn);
                        cnt_d   = '0;
                        neg_d   = start_sgn & (rs[31] ^ rt[31]);
                        busy_d  = 1'b1;
                        state_d = MD_CALC;
`ifdef EXECUTE_DIV_EN
                        div_d     = start_is_div;
                        div0_d    = start_is_div && (rt == 32'd0);
                        neg_rem_d = start_sgn & rs[31];
                        if (start_is_div && (rt == 32'd0)) begin
                            work_d  = rs;
                            state_d = MD_FIX;
                        end
`endif
                    end
                end
            end
            MD_CALC: begin
                acc_d  = mul_sum[32:1];
                work_d = {mul_sum[0], work_q[31:1]};
`ifdef EXECUTE_DIV_EN
                if (div_q) begin
                    acc_d  = rem_ge ? rem_sub : rem_sh[31:0];
                    work_d = {work_q[30:0], rem_ge};
                end
`endif
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MD_ITERS - 1)) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                hi_d = prod_fix[63:32];
                lo_d = prod_fix[31:0];
`ifdef EXECUTE_DIV_EN
                if (div0_q) begin
                    hi_d = work_q;
                    lo_d = 32'hFFFF_FFFF;
                end else if (div_q) begin
                    lo_d = neg_q ? (32'd0 - work_q) : work_q;
                    hi_d = neg_rem_q ? (32'd0 - acc_q) : acc_q;
                end
`endif
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = MD_DONE;
            end
            MD_DONE: begin
                done_d  = 1'b0;
                state_d = MD_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MD_IDLE;
            acc_q   <= '0;
            work_q  <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef EXECUTE_DIV_EN
            div_q     <= 1'b0;
            div0_q    <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            work_q  <= work_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef EXECUTE_DIV_EN
            div_q     <= div_d;
            div0_q    <= div0_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/execute.sv
// Execute stage: combinational ALU / MFHI / MFLO mux with zero flag around the
// iterative muldiv_unit. Define EXECUTE_DIV_EN to include DIV/DIVU.
module execute
    import execute_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  aluOp,
    input  logic [4:0]  shamt,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    output logic [31:0] aluResult,
    output logic        zero,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    muldiv_unit u_muldiv (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op      (aluOp),
        .rs      (readData1),
        .rt      (readData2),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    // Shifts act on rt, matching MIPS SLL/SRL.
    always_comb begin
        aluResult = '0;
        case (aluOp)
            ALU_ADD:  aluResult = readData1 + readData2;
            ALU_SUB:  aluResult = readData1 - readData2;
            ALU_AND:  aluResult = readData1 & readData2;
            ALU_OR:   aluResult = readData1 | readData2;
            ALU_NOR:  aluResult = ~(readData1 | readData2);
            ALU_SLT:  aluResult = {31'd0, $signed(readData1) < $signed(readData2)};
            ALU_SLL:  aluResult = readData2 << shamt;
            ALU_SRL:  aluResult = readData2 >> shamt;
            ALU_MFHI: aluResult = hi;
            ALU_MFLO: aluResult = lo;
            default:  aluResult = '0;
        endcase
    end

    assign zero = (aluResult == 32'd0);

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: ALU, multiply/divide, hold/ignore rules, reset abort.
module tb_execute;
    import execute_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  aluOp;
    logic [4:0]  shamt;
    logic [31:0] readData1, readData2;
    logic [31:0] aluResult, hi, lo;
    logic        zero, busy, done;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    execute dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .aluOp     (aluOp),
        .shamt     (shamt),
        .readData1 (readData1),
        .readData2 (readData2),
        .aluResult (aluResult),
        .zero      (zero),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] h, input logic [31:0] l);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        q  = 0;
        r  = 0;
        case (op)
            ALU_MULT:  return 64'(sa * sb);
            ALU_MULTU: return ua * ub;
`ifdef EXECUTE_DIV_EN
            ALU_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            ALU_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
            end
`endif
            default: return {h, l};
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh, input logic [31:0] h, input logic [31:0] l);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_NOR:  return ~(a | b);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL:  return b << sh;
            ALU_SRL:  return b >> sh;
            ALU_MFHI: return h;
            ALU_MFLO: return l;
            default:  return 32'd0;
        endcase
    endfunction

    // Caller is just past a negedge. Returns the cycle (1 = first cycle after
    // the start edge) in which done was seen, and how many earlier cycles lacked busy.
    task automatic do_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int lat, output int busy_bad);
        aluOp = op; readData1 = a; readData2 = b; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        busy_bad = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic check_md(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int exp_lat);
        int lat, bb;
        logic [63:0] e;
        e = ref_md(op, a, b, exp_hi, exp_lo);
        do_muldiv(op, a, b, lat, bb);
        checks++;
        if (lat !== exp_lat || bb !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s timing: done cycle %0d busy gaps %0d busy %b, required cycle %0d gaps 0 busy 0",
                     name, lat, bb, busy, exp_lat);
        end
        checks++;
        if (hi !== e[63:32] || lo !== e[31:0]) begin
            errors++;
            $display("FAIL %s result: hi %h lo %h, required hi %h lo %h", name, hi, lo, e[63:32], e[31:0]);
        end
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; aluOp = ALU_ADD; shamt = 5'd0;
        readData1 = 32'd0; readData2 = 32'd0;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy %b done %b hi %h lo %h, required all zero", busy, done, hi, lo);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_alu;
        logic [31:0] e;
        logic [3:0]  ops[3]  = '{ALU_ADD, ALU_SUB, ALU_SLT};
        logic [31:0] as[3]   = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF};
        logic [31:0] bs[3]   = '{32'd1, 32'd5, 32'd1};
        logic [31:0] rs[3]   = '{32'h8000_0000, 32'd0, 32'd1};
        for (int i = 0; i < 3; i++) begin
            aluOp = ops[i]; readData1 = as[i]; readData2 = bs[i]; shamt = 5'd0;
            #1;
            checks++;
            if (aluResult !== rs[i] || zero !== (rs[i] == 32'd0)) begin
                errors++;
                $display("FAIL alu_directed%0d: result %h zero %b, required %h zero %b",
                         i, aluResult, zero, rs[i], rs[i] == 32'd0);
            end
        end
        for (int i = 0; i < 24; i++) begin
            aluOp = 4'($urandom_range(0, 9));
            readData1 = $urandom;
            readData2 = (i % 4 == 0) ? readData1 : $urandom;
            shamt = 5'($urandom);
            #1;
            e = ref_alu(aluOp, readData1, readData2, shamt, exp_hi, exp_lo);
            checks++;
            if (aluResult !== e || zero !== (e == 32'd0)) begin
                errors++;
                $display("FAIL alu_random op %0d a %h b %h sh %0d: result %h zero %b, required %h",
                         aluOp, readData1, readData2, shamt, aluResult, zero, e);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_mult;
        check_md("mult_neg3x7", ALU_MULT, 32'hFFFF_FFFD, 32'd7, 34);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mult_neg3x7_const: hi %h lo %h, required ffffffff ffffffeb", hi, lo);
        end
        check_md("multu_max_x2", ALU_MULTU, 32'hFFFF_FFFF, 32'd2, 34);
        check_md("mult_minint", ALU_MULT, 32'h8000_0000, 32'h8000_0000, 34);
        for (int i = 0; i < 6; i++)
            check_md("mul_random", (i % 2 == 0) ? ALU_MULT : ALU_MULTU, $urandom, $urandom, 34);
    endtask

`ifdef EXECUTE_DIV_EN
    task automatic test_div;
        logic [31:0] b;
        check_md("div_neg7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 34);
        check_md("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 34);
        check_md("div_by_zero", ALU_DIV, 32'd9, 32'd0, 2);
        check_md("div_minint_m1", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34);
        for (int i = 0; i < 6; i++) begin
            b = (i == 5) ? 32'd0 : ((i % 2 == 0) ? ($urandom & 32'h0000_FFFF) | 32'd1 : $urandom);
            check_md("div_random", (i % 2 == 0) ? ALU_DIV : ALU_DIVU, $urandom, b, (b == 32'd0) ? 2 : 34);
        end
    endtask
`else
    task automatic test_no_div;
        check_md("divu_disabled", ALU_DIVU, 32'd8, 32'd2, 1);
        check_md("div_disabled", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1);
        check_md("mult_after_div", ALU_MULT, 32'd11, 32'hFFFF_FFFE, 34);
    endtask
`endif

    task automatic test_hold;
        int cyc;
        logic [63:0] e;
        e = ref_md(ALU_MULT, 32'h0001_2345, 32'hFFFF_FFB3, exp_hi, exp_lo);
        aluOp = ALU_MULT; readData1 = 32'h0001_2345; readData2 = 32'hFFFF_FFB3; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            if (cyc == 5) begin
                readData1 = $urandom; readData2 = $urandom; aluOp = ALU_MULTU; start = 1'b1;
            end
            if (cyc == 8) begin
                aluOp = ALU_MFLO;
                #1;
                checks++;
                if (aluResult !== exp_lo) begin
                    errors++;
                    $display("FAIL mflo_busy: result %h, required old lo %h", aluResult, exp_lo);
                end
                aluOp = ALU_MULT;
            end
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (cyc !== 34 || hi !== e[63:32] || lo !== e[31:0]) begin
            errors++;
            $display("FAIL hold_operands: cycle %0d hi %h lo %h, required cycle 34 hi %h lo %h",
                     cyc, hi, lo, e[63:32], e[31:0]);
        end
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: busy %b done %b, required 0 0", busy, done);
        end
        start = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_abort;
        int lat, bb;
        aluOp = ALU_MULT; readData1 = $urandom | 32'h1; readData2 = $urandom | 32'h1; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort: busy %b done %b hi %h lo %h, required all zero", busy, done, hi, lo);
        end
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clock);
        reset_n = 1'b1;
        do_muldiv(ALU_MULT, 32'd2, 32'd3, lat, bb);
        checks++;
        if (lat !== 34 || bb !== 0 || lo !== 32'd6 || hi !== 32'd0) begin
            errors++;
            $display("FAIL mult_after_reset: cycle %0d gaps %0d hi %h lo %h, required cycle 34 hi 0 lo 6",
                     lat, bb, hi, lo);
        end
        exp_lo = 32'd6;
        @(negedge clock);
    endtask

    initial begin
        test_reset;
        test_alu;
        test_mult;
`ifdef EXECUTE_DIV_EN
        test_div;
`else
        test_no_div;
`endif
        test_hold;
        test_reset_abort;
        test_alu;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 The module SHALL have ports: clock  input  1  rising-edge clock for all state.
REQ-002 The module SHALL have ports: reset_n  input  1  asynchronous, active-low reset.
REQ-003 The module SHALL have ports: start  input  1  request for a multiply/divide op; sampled only in IDLE.
REQ-004 The module SHALL have ports: aluOp  input  4  operation select (encodings in shared package).
REQ-005 The module SHALL have ports: shamt  input  5  shift amount for SLL/SRL.
REQ-006 The module SHALL have ports: readData1, readData2  input  32 each  signed operands rs/rt from register-file read.
REQ-007 The module SHALL have ports: aluResult  output  32  combinational ALU/MFHI/MFLO result.
REQ-008 The module SHALL have ports: zero  output  1  aluResult == 0.
REQ-009 The module SHALL have ports: busy  output  1  multiply/divide in progress.
REQ-010 The module SHALL have ports: done  output  1  one-cycle pulse; HI/LO valid.
REQ-011 The module SHALL have ports: hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-012 ADD, SUB, AND, OR, NOR, SLT (signed), SLL, SRL SHALL be combinational on aluResult with 32-bit wrap-around and no overflow trap.
REQ-013 MFHI/MFLO SHALL drive hi/lo onto aluResult, including old values while busy; hazards are the controller's job.
REQ-014 MULT, MULTU, DIV and DIVU SHALL start only when start=1, state=IDLE and aluOp is one of them; otherwise start is ignored.
REQ-015 FSM SHALL be IDLE -> CALC (32 cycles, 1 bit/cycle, shift-add multiply or restoring divide on magnitudes) -> FIX (1 cycle: sign correction, HI/LO load) -> DONE (1 cycle) -> IDLE.
REQ-016 Operands and op SHALL be latched at the start edge; later changes to readData1/readData2/aluOp SHALL NOT affect the result.
REQ-017 busy SHALL be 1 in CALC and FIX and 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-018 Total latency SHALL be 34 cycles from the start edge to done=1, with hi/lo updated at the same edge as done rises.
REQ-019 Multiply SHALL give {hi,lo} = full 64-bit product, signed for MULT and unsigned for MULTU.
REQ-020 Divide SHALL give lo = quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-021 Divide by zero SHALL skip CALC (IDLE -> FIX -> DONE, latency 2) and give lo = 32'hFFFFFFFF, hi = readData1.
REQ-022 DIV of 32'h80000000 by -1 SHALL give lo = 32'h80000000, hi = 0.
REQ-023 start asserted in the DONE cycle SHALL be ignored; a new op SHALL need IDLE.

Reset
REQ-024 reset_n=0 SHALL immediately force state=IDLE, hi=0, lo=0, busy=0, done=0, and clear all internal iteration registers.
REQ-025 Reset asserted mid-operation SHALL abort the op with no partial HI/LO update; after release the module SHALL accept start on the first clock edge.

Configuration
REQ-026 Macro EXECUTE_DIV_EN defined SHALL compile in the DIV/DIVU datapath as specified.
REQ-027 Without EXECUTE_DIV_EN, DIV/DIVU with start SHALL go IDLE -> DONE (done one cycle after the start edge) with hi/lo unchanged; multiply is unaffected.

Structure
REQ-028 A shared package SHALL hold the aluOp encodings, the FSM state encoding and the 32-iteration count constant.
REQ-029 The iterative multiply/divide datapath and FSM SHALL be one sub-module, muldiv_unit; the ALU mux and zero flag stay in execute.

Verification
REQ-030 Verify: ADD 32'h7FFFFFFF+1 -> aluResult 32'h80000000, zero=0; SUB 5-5 -> 0, zero=1; SLT -1,1 -> 1.
REQ-031 Verify: MULT -3 x 7 with start -> busy for cycles 1-33, done at cycle 34, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; MULTU 32'hFFFFFFFF x 2 -> hi=1, lo=32'hFFFFFFFE.
REQ-032 Verify: DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 100 / 7 -> lo=14, hi=2; DIV 9 / 0 -> done after 2 cycles, lo=32'hFFFFFFFF, hi=9.
REQ-033 Verify: change operands and assert start during CALC -> result unchanged, no restart; MFLO during busy -> old lo.
REQ-034 Verify: reset_n low at cycle 10 of MULT -> busy=0 and hi=lo=0 at once; a new MULT 2 x 3 afterwards -> lo=6.
REQ-035 Verify: build without EXECUTE_DIV_EN, DIVU 8/2 -> done one cycle after the start edge, hi/lo hold prior values.
